// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, ALUOp encodings and the
// multiply sequencer state type.
package alu_pkg;

    // ALU control codes from the ALU control decoder
    localparam logic [3:0] AND_OP = 4'd0;
    localparam logic [3:0] OR_OP  = 4'd1;
    localparam logic [3:0] ADD_OP = 4'd2;
    localparam logic [3:0] SLL_OP = 4'd3;
    localparam logic [3:0] SRL_OP = 4'd4;
    localparam logic [3:0] SUB_OP = 4'd6;
    localparam logic [3:0] SLT_OP = 4'd7;
    localparam logic [3:0] MUL_OP = 4'd8;

    // ALUOp codes from the main decoder
    localparam logic [1:0] ADD    = 2'b00;
    localparam logic [1:0] SUB    = 2'b01;
    localparam logic [1:0] R_TYPE = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/mul_sequencer.sv
// Iterative radix-2 shift-add multiplier for the EX stage. Holds the
// pipeline for a fixed DATA_W iterations, then presents the low product.
module mul_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CNT_W  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              start,
    input  logic [3:0]        alu_control,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic              flush,
    output logic              stall,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    mul_state_e        state, state_n;
    logic [DATA_W-1:0] mcand, mplier, acc, acc_sum;
    logic [CNT_W-1:0]  cnt;
    logic              is_mul, accept, last;

    assign is_mul  = start && (alu_control == MUL_OP);
    assign acc_sum = acc + (mplier[0] ? mcand : '0);

    // Combinational so the pipeline freezes in the acceptance cycle; forced
    // low during reset so every output reads as idle immediately.
    assign stall = !arst && (((state == IDLE) && is_mul) || (state == RUN));

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        last    = 1'b0;
        if (flush) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: if (is_mul) begin
                    accept  = 1'b1;
                    state_n = RUN;
                end
                RUN: if (cnt == LAST_CNT) begin
                    last    = 1'b1;
                    state_n = DONE;
                end
                DONE:    state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            acc    <= '0;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else begin
            state <= state_n;
            busy  <= (state_n == RUN);
            done  <= (state_n == DONE);
            if (accept) begin
                mcand  <= operand_a;
                mplier <= operand_b;
                acc    <= '0;
                cnt    <= '0;
            end else if ((state == RUN) && !flush) begin
                acc    <= acc_sum;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
            end
            // Final iteration's sum goes straight to result
            if (last)
                result <= acc_sum;
        end
    end

endmodule
